// File: rtl/lane_instr_queue.sv
// lane_instr_queue: per-lane show-ahead instruction FIFO between the
// fetch-side distributor and the lane decode stage.
//
// Optional feature: define LANE_QUEUE_BYPASS_EN to let a word pushed into an
// empty queue appear on pop_data in the same cycle (and be consumed without
// being stored when pop_ready is high). Default build has no bypass.
//
// Handshake: a transfer happens on a rising edge where valid && ready on that
// side. push_ready depends only on state (!full). pop_valid depends only on
// state in the default build; with bypass it also follows push_valid while
// the queue is empty. Neither side may make valid wait on ready.
module lane_instr_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  input  logic              pop_ready,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_q;
  logic              overflow_q;
  logic              do_push;
  logic              do_pop;
  logic              bypass_take;

  assign count      = count_q;
  assign overflow   = overflow_q;
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign push_ready = !full;

  // Output side selection and transfer qualification.
  always_comb begin
    bypass_take = 1'b0;
    pop_valid   = !empty;
    pop_data    = '0;
`ifdef LANE_QUEUE_BYPASS_EN
    // Empty queue forwards the incoming word straight to the decode stage.
    bypass_take = empty && push_valid && pop_ready;
    pop_valid   = !empty || push_valid;
    if (!empty)
      pop_data = mem[rd_ptr];
    else if (push_valid)
      pop_data = push_data;
`else
    // Gate the read so a freshly reset queue shows zero, not stale memory.
    if (!empty)
      pop_data = mem[rd_ptr];
`endif
    // A bypassed word is consumed directly and never occupies an entry.
    do_push = push_valid && push_ready && !bypass_take;
    do_pop  = !empty && pop_ready;
  end

  // Storage array: written on an accepted push, not cleared by reset.
  always_ff @(posedge clk) begin
    if (resetn && do_push)
      mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Pointers are AW bits wide and DEPTH is a power of two, so they wrap.
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_valid && full)
        overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lane_instr_queue.sv
// tb_lane_instr_queue: table-driven fill/overflow/drain vectors, hand-written
// reset, wrap, steady-state, bypass and mid-operation reset sequences, and a
// random soak, all checked against an expected-word queue.
module tb_lane_instr_queue;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
`ifdef LANE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              resetn;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic              pop_ready;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              overflow;

  lane_instr_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_ready  (pop_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  // Clock and initial reset level.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state.
  logic [DATA_W-1:0] exp_q[$];
  logic              ovf_m;
  int                n_vec;
  int                n_err;
  int                n_popped;

  typedef struct {
    logic              pv;
    logic [DATA_W-1:0] pd;
    logic              pr;
    logic [AW:0]       cnt;
    logic              f;
    logic              e;
    logic              o;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus with pre-edge output checks and post-edge
  // state checks against the scoreboard model.
  task automatic step(input logic pv, input logic [DATA_W-1:0] pd, input logic pr);
    int sz;
    logic exp_pv;
    logic acc;
    logic byp;
    @(negedge clk);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    #1;
    sz = exp_q.size();
    chk("push_ready", push_ready, (sz < DEPTH));
    exp_pv = (sz != 0) || (BYP && pv);
    chk("pop_valid", pop_valid, exp_pv);
    if (exp_pv)
      chk("pop_data", pop_data, (sz != 0) ? exp_q[0] : pd);
    if (exp_pv && pr) begin
      chk("no_dropped_word", (pop_data == 32'hDEADBEEF), 0);
      n_popped++;
    end
    acc = pv && (sz < DEPTH);
    byp = BYP && (sz == 0) && pv && pr;
    if (sz != 0 && pr)
      void'(exp_q.pop_front());
    if (acc && !byp)
      exp_q.push_back(pd);
    if (pv && sz == DEPTH)
      ovf_m = 1'b1;
    @(posedge clk);
    #1;
    chk("count", count, exp_q.size());
    chk("full", full, (exp_q.size() == DEPTH));
    chk("empty", empty, (exp_q.size() == 0));
    chk("overflow", overflow, ovf_m);
  endtask

  // Hold reset for n cycles with traffic on both sides, then check idle outputs.
  task automatic apply_reset(input int n);
    @(negedge clk);
    resetn     = 1'b0;
    push_valid = 1'b1;
    push_data  = 32'h5A5A5A5A;
    pop_ready  = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    resetn     = 1'b1;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    #1;
    exp_q.delete();
    ovf_m = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_pop_data", pop_data, 0);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    n_popped   = 0;
    ovf_m      = 1'b0;
    resetn     = 1'b0;
    push_valid = 1'b1;
    push_data  = '0;
    pop_ready  = 1'b0;

    // Fill 0x1..0x8, drop 0xDEADBEEF while full, then drain in order.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, DATA_W'(i + 1), 1'b0, 4'(i + 1), (i == 7), 1'b0, 1'b0};
    tbl[8] = '{1'b1, 32'hDEADBEEF, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};
    for (int i = 9; i < 17; i++)
      tbl[i] = '{1'b0, 32'h0, 1'b1, 4'(16 - i), 1'b0, (i == 16), 1'b1};

    apply_reset(2);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].pv, tbl[i].pd, tbl[i].pr);
      chk("tbl_count", count, tbl[i].cnt);
      chk("tbl_full", full, tbl[i].f);
      chk("tbl_empty", empty, tbl[i].e);
      chk("tbl_overflow", overflow, tbl[i].o);
    end

    // Wrap: build occupancy to 3, then push with continuous pop_ready.
    n_popped = 0;
    for (int i = 0; i < 3; i++)
      step(1'b1, DATA_W'(32'h100 + i), 1'b0);
    for (int i = 3; i < 20; i++)
      step(1'b1, DATA_W'(32'h100 + i), 1'b1);
    while (exp_q.size() != 0 && n_popped < 40)
      step(1'b0, '0, 1'b1);
    chk("wrap_popped", n_popped, 20);
    chk("wrap_overflow_sticky", overflow, 1);

    // Steady push/pop at count 4.
    for (int i = 0; i < 4; i++)
      step(1'b1, DATA_W'(32'h200 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DATA_W'(32'h300 + i), 1'b1);
      chk("steady_count", count, 4);
    end
    for (int i = 0; i < 4; i++)
      step(1'b0, '0, 1'b1);

    // Pop while empty is ignored.
    step(1'b0, '0, 1'b1);
    chk("empty_pop_count", count, 0);

    // Reset in the middle of traffic discards stored words.
    for (int i = 0; i < 3; i++)
      step(1'b1, DATA_W'(32'h400 + i), 1'b0);
    apply_reset(1);
    step(1'b1, 32'h500, 1'b0);
    step(1'b0, '0, 1'b1);

    // Push into an empty queue with pop_ready high.
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = 32'hCAFE0001;
    pop_ready  = 1'b1;
    #1;
`ifdef LANE_QUEUE_BYPASS_EN
    chk("byp_pop_valid", pop_valid, 1);
    chk("byp_pop_data", pop_data, 32'hCAFE0001);
    @(posedge clk);
    #1;
    chk("byp_count", count, 0);
    chk("byp_empty", empty, 1);
`else
    chk("nobyp_pop_valid0", pop_valid, 0);
    @(posedge clk);
    #1;
    chk("nobyp_count1", count, 1);
    @(negedge clk);
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    #1;
    chk("nobyp_pop_valid1", pop_valid, 1);
    chk("nobyp_pop_data", pop_data, 32'hCAFE0001);
    @(posedge clk);
    #1;
    chk("nobyp_count0", count, 0);
`endif

    // Random soak.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lane_instr_queue.md
LANE_INSTR_QUEUE -- requirements
Module: lane_instr_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of entries; power of two, >= 2.
REQ-003 The block SHALL have parameter AW, default 3, meaning pointer width; equals log2(DEPTH).
REQ-004 The block SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-005 The block SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-006 The block SHALL have port push_valid, input, 1, lane-side instruction write request from the fetch-side distributor.
REQ-007 The block SHALL have port push_data, input, DATA_W, instruction word to enqueue.
REQ-008 The block SHALL have port push_ready, output, 1, queue can accept a word this cycle.
REQ-009 The block SHALL have port pop_valid, output, 1, head word available to the lane decode stage.
REQ-010 The block SHALL have port pop_data, output, DATA_W, head instruction word.
REQ-011 The block SHALL have port pop_ready, input, 1, decode stage consumes head this cycle.
REQ-012 The block SHALL have port count, output, AW+1, number of stored entries, 0..DEPTH.
REQ-013 The block SHALL have port full, output, 1, count == DEPTH.
REQ-014 The block SHALL have port empty, output, 1, count == 0.
REQ-015 The block SHALL have port overflow, output, 1, sticky flag: a push was attempted while full.

Function
REQ-016 push_ready SHALL equal !full, combinationally.
REQ-017 A push SHALL occur when push_valid && push_ready; push_data is written at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-018 pop_valid SHALL equal !empty; pop_data SHALL equal mem[rd_ptr] (show-ahead, no read latency).
REQ-019 A pop SHALL occur when pop_valid && pop_ready; rd_ptr increments modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push-only adds 1, pop-only subtracts 1.
REQ-021 When full, a simultaneous push and pop SHALL accept only the pop; the push is refused because push_ready is 0.
REQ-022 push_valid while full SHALL drop the word, leave the memory and pointers unchanged, and set overflow to 1 on the next edge.
REQ-023 overflow SHALL remain 1 until reset.
REQ-024 pop_ready while empty SHALL be ignored, with no pointer or count change, except as permitted by REQ-030.
REQ-025 Pointer wrap SHALL be seamless: a word written at index DEPTH-1 followed by a write at index 0 preserves FIFO order.
REQ-026 Output order SHALL equal accepted push order with no duplication or loss, apart from overflow drops.

Reset
REQ-027 When resetn is 0 at a rising edge, wr_ptr, rd_ptr, count and overflow SHALL be cleared to 0.
REQ-028 Reset SHALL leave outputs at empty=1, full=0, pop_valid=0, push_ready=1, count=0, overflow=0, pop_data=0.
REQ-029 Reset mid-operation SHALL discard all stored entries; pushes and pops in the reset cycle SHALL be ignored, and memory contents need not be cleared.

Configuration
REQ-030 With macro LANE_QUEUE_BYPASS_EN defined, when empty and push_valid=1: pop_valid SHALL be 1 and pop_data SHALL equal push_data in the same cycle. If pop_ready=1 in that cycle, the word is consumed without being written and count stays 0; otherwise the word is written normally.
REQ-031 Without LANE_QUEUE_BYPASS_EN, a word pushed into an empty queue SHALL first appear on pop_data one cycle after the push edge, and pop_valid SHALL be 0 in the push cycle.

Verification
REQ-032 The bench SHALL check reset: hold resetn=0 for 2 cycles with push_valid=1 -> count=0, empty=1, overflow=0 after release.
REQ-033 The bench SHALL check fill/drain: push 0x00000001..0x00000008 with pop_ready=0 -> full=1 and count=8; then pop 8 words -> data 0x1..0x8 in order, empty=1.
REQ-034 The bench SHALL check overflow: with the queue full, push 0xDEADBEEF -> overflow=1, count stays 8, and 0xDEADBEEF never appears at pop_data.
REQ-035 The bench SHALL check wrap: run 20 pushes (0x100+i) with continuous pop_ready=1 and queue occupancy 1..3 -> output sequence 0x100..0x113 exact.
REQ-036 The bench SHALL check simultaneous push/pop at count=4 for 10 cycles -> count stays 4.
REQ-037 The bench SHALL check the bypass path: from empty, push 0xCAFE0001 with pop_ready=1. With LANE_QUEUE_BYPASS_EN, pop_data=0xCAFE0001 in the same cycle and count stays 0. Without it, pop_valid=0 that cycle, then pop_valid=1 with 0xCAFE0001 next cycle.
